// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared state type, round-constant values and
// default round count for the AES round controller.
package aes_ctrl_pkg;

  localparam int NR_DEF = 10;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    FINAL,
    DONE
  } ctrl_state_e;

  // GF(2^8) doubling used by the key expansion round constant.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    logic [7:0] r;
    r = {b[6:0], 1'b0};
    if (b[7]) begin
      r = r ^ RCON_POLY;
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: request/ack handshake plus the datapath
// control strobes of the AES round controller.
interface aes_round_ctrl_if;

  logic       start;
  logic       ack;
  logic       busy;
  logic       done;
  logic       ld_state;
  logic       ld_key;
  logic       state_en;
  logic       key_en;
  logic [3:0] round;
  logic       last_round;
  logic [7:0] rcon;

  // Requester / consumer side.
  modport master (
    output start,
    output ack,
    input  busy,
    input  done,
    input  ld_state,
    input  ld_key,
    input  state_en,
    input  key_en,
    input  round,
    input  last_round,
    input  rcon
  );

  // Controller side.
  modport slave (
    input  start,
    input  ack,
    output busy,
    output done,
    output ld_state,
    output ld_key,
    output state_en,
    output key_en,
    output round,
    output last_round,
    output rcon
  );

endinterface

// File: rtl/aes_rcon_gen.sv
// aes_rcon_gen: round-constant register, reloaded to 0x01
// before round 1 and doubled in GF(2^8) after every round.
module aes_rcon_gen
  import aes_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       reload_i,
  input  logic       en_i,
  output logic [7:0] rcon_o
);

  logic [7:0] rcon_q;
  logic [7:0] rcon_d;

  // Next constant: reload has priority over the xtime step.
  always_comb begin
    rcon_d = rcon_q;
    if (reload_i) begin
      rcon_d = RCON_INIT;
    end else if (en_i) begin
      rcon_d = xtime(rcon_q);
    end
  end

  // Constant register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rcon_q <= RCON_INIT;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: IDLE/LOAD/ROUND/FINAL/DONE sequencer for an
// iterative AES datapath. Define AES_ABORT_EN to add the abort port.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR = NR_DEF
) (
  input  logic            clk,
  input  logic            rst,
`ifdef AES_ABORT_EN
  input  logic            abort,
`endif
  aes_round_ctrl_if.slave bus
);

  localparam logic [3:0] RND_LAST = 4'(NR - 1);
  localparam logic [3:0] RND_FIN  = 4'(NR);

  ctrl_state_e state_q;
  logic [3:0]  round_q;
  logic        busy_q;
  logic        done_q;
  logic        ld_state_q;
  logic        ld_key_q;
  logic        state_en_q;
  logic        key_en_q;
  logic        last_q;
  logic [7:0]  rcon_raw;
  logic        abort_hit;

`ifdef AES_ABORT_EN
  // Abort only counts while an operation is in flight.
  assign abort_hit = abort && busy_q;
`else
  assign abort_hit = 1'b0;
`endif

  // Sequencer with every output registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst || abort_hit) begin
      state_q    <= IDLE;
      round_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ld_state_q <= 1'b0;
      ld_key_q   <= 1'b0;
      state_en_q <= 1'b0;
      key_en_q   <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= LOAD;
            busy_q     <= 1'b1;
            ld_state_q <= 1'b1;
            ld_key_q   <= 1'b1;
            round_q    <= '0;
          end
        end
        LOAD: begin
          state_q    <= ROUND;
          ld_state_q <= 1'b0;
          ld_key_q   <= 1'b0;
          state_en_q <= 1'b1;
          key_en_q   <= 1'b1;
          round_q    <= 4'd1;
        end
        ROUND: begin
          if (round_q == RND_LAST) begin
            state_q <= FINAL;
            round_q <= RND_FIN;
            last_q  <= 1'b1;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        FINAL: begin
          state_q    <= DONE;
          busy_q     <= 1'b0;
          state_en_q <= 1'b0;
          key_en_q   <= 1'b0;
          last_q     <= 1'b0;
          done_q     <= 1'b1;
          round_q    <= '0;
        end
        DONE: begin
          // ack wins over a simultaneous start.
          if (bus.ack) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          round_q    <= '0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          ld_state_q <= 1'b0;
          ld_key_q   <= 1'b0;
          state_en_q <= 1'b0;
          key_en_q   <= 1'b0;
          last_q     <= 1'b0;
        end
      endcase
    end
  end

  aes_rcon_gen u_rcon (
    .clk      (clk),
    .rst      (rst),
    .reload_i (state_q == LOAD),
    .en_i     (key_en_q),
    .rcon_o   (rcon_raw)
  );

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.ld_state   = ld_state_q;
  assign bus.ld_key     = ld_key_q;
  assign bus.state_en   = state_en_q;
  assign bus.key_en     = key_en_q;
  assign bus.round      = round_q;
  assign bus.last_round = last_q;
  // Constant is only meaningful while rounds run.
  assign bus.rcon       = state_en_q ? rcon_raw : 8'h00;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: scoreboard bench for aes_round_ctrl, one
// expected output vector per clock queued when stimulus is driven.
module tb_aes_round_ctrl;

  localparam int NR = 10;

  typedef struct {
    string       tag;
    logic [18:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
`ifdef AES_ABORT_EN
  logic abort;
`endif

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [7:0] rc_tbl [0:9];

  aes_round_ctrl_if bus ();

  aes_round_ctrl #(.NR(NR)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef AES_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] vec(
    logic b, logic d, logic ls, logic lk, logic en, logic lr,
    logic [3:0] r, logic [7:0] c);
    return {b, d, ls, lk, en, en, lr, r, c};
  endfunction

  function automatic logic [18:0] got();
    return {bus.busy, bus.done, bus.ld_state, bus.ld_key,
            bus.state_en, bus.key_en, bus.last_round,
            bus.round, bus.rcon};
  endfunction

  function automatic logic [18:0] idle_v();
    return vec(0, 0, 0, 0, 0, 0, 4'd0, 8'h00);
  endfunction

  function automatic logic [18:0] done_v();
    return vec(0, 1, 0, 0, 0, 0, 4'd0, 8'h00);
  endfunction

  // Cycle i of an operation, i=0 is LOAD.
  function automatic logic [18:0] op_v(int i);
    if (i == 0) return vec(1, 0, 1, 1, 0, 0, 4'd0, 8'h00);
    if (i < NR) return vec(1, 0, 0, 0, 1, 0, 4'(i), rc_tbl[i-1]);
    if (i == NR) return vec(1, 0, 0, 0, 1, 1, 4'(NR), rc_tbl[NR-1]);
    return done_v();
  endfunction

  task automatic chk(input string tag, input logic [31:0] g,
                     input logic [31:0] e);
    n_chk++;
    if (g === e) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h exp=%h", tag, g, e);
    end
  endtask

  task automatic push(input string tag, input logic [18:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic push_op(input string tag, input int n);
    for (int i = 0; i < NR + 2 && i < n; i++) begin
      push($sformatf("%s.c%0d", tag, i), op_v(i));
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, {13'd0, got()}, {13'd0, e.v});
    end
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() > 0 && g < 200) begin
      step();
      g++;
    end
    if (sb.size() > 0) begin
      chk("drain", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic ack_idle(input string tag);
    bus.ack = 1'b1;
    push(tag, idle_v());
    step();
    bus.ack = 1'b0;
  endtask

  initial begin
    rc_tbl[0] = 8'h01; rc_tbl[1] = 8'h02;
    rc_tbl[2] = 8'h04; rc_tbl[3] = 8'h08;
    rc_tbl[4] = 8'h10; rc_tbl[5] = 8'h20;
    rc_tbl[6] = 8'h40; rc_tbl[7] = 8'h80;
    rc_tbl[8] = 8'h1b; rc_tbl[9] = 8'h36;

    rst       = 1'b0;
    bus.start = 1'b0;
    bus.ack   = 1'b0;
`ifdef AES_ABORT_EN
    abort = 1'b0;
`endif

    // reset state
    push("rst.a", idle_v());
    push("rst.b", idle_v());
    drain();

    // start on the first edge after reset release
    rst       = 1'b1;
    bus.start = 1'b1;
    push_op("op1", NR + 2);
    step();
    bus.start = 1'b0;
    drain();
    for (int i = 0; i < 3; i++) push("op1.hold", done_v());
    drain();
    ack_idle("op1.ack");
    push("op1.idle", idle_v());
    drain();

    // start held 20 cycles: single op, done held
    bus.start = 1'b1;
    push_op("held", NR + 2);
    for (int i = 0; i < 8; i++) push("held.done", done_v());
    drain();
    bus.start = 1'b0;

    // ack delayed, then start+ack together
    for (int i = 0; i < 5; i++) push("dly.done", done_v());
    drain();
    bus.start = 1'b1;
    bus.ack   = 1'b1;
    push("sa.idle", idle_v());
    step();
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    push("sa.noload", idle_v());
    push("sa.noload", idle_v());
    drain();
    bus.start = 1'b1;
    push_op("op3", NR + 2);
    step();
    bus.start = 1'b0;
    drain();
    ack_idle("op3.ack");

    // reset in round 5
    bus.start = 1'b1;
    push_op("mid", 6);
    step();
    bus.start = 1'b0;
    drain();
    rst = 1'b0;
    push("mid.rst", idle_v());
    step();
    rst = 1'b1;
    push("mid.idle", idle_v());
    step();
    bus.start = 1'b1;
    push_op("op4", NR + 2);
    step();
    bus.start = 1'b0;
    drain();
    ack_idle("op4.ack");

`ifdef AES_ABORT_EN
    // abort in round 3
    bus.start = 1'b1;
    push_op("ab", 4);
    step();
    bus.start = 1'b0;
    drain();
    abort = 1'b1;
    push("ab.idle", idle_v());
    step();
    abort = 1'b0;
    for (int i = 0; i < 3; i++) push("ab.nodone", idle_v());
    drain();

    // abort ignored in IDLE and DONE
    abort     = 1'b1;
    bus.start = 1'b1;
    push_op("abi", 1);
    step();
    abort     = 1'b0;
    bus.start = 1'b0;
    push_op("abi", NR + 2);
    void'(sb.pop_front());
    drain();
    abort = 1'b1;
    push("abd.done", done_v());
    step();
    abort = 1'b0;
    ack_idle("abd.ack");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter: NR, default 10, number of AES rounds; legal range 2..14.
REQ-002 Port: clk  input  1  clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-low.
REQ-004 Port: start  input  1  request one block operation; sampled only in IDLE.
REQ-005 Port: ack  input  1  consumer has taken the result; sampled only in DONE.
REQ-006 Port: busy  output  1  high in LOAD, ROUND, FINAL.
REQ-007 Port: done  output  1  result valid; held until ack.
REQ-008 Port: ld_state  output  1  datapath loads plaintext XOR key.
REQ-009 Port: ld_key  output  1  key register loads the cipher key.
REQ-010 Port: state_en  output  1  state register advances one round.
REQ-011 Port: key_en  output  1  key schedule advances one round.
REQ-012 Port: round  output  4  current round index, 0..NR.
REQ-013 Port: last_round  output  1  current round omits MixColumns.
REQ-014 Port: rcon  output  8  round constant for the key expansion in this round.
REQ-015 Port: abort  input  1  cancel the operation in flight (only with AES_ABORT_EN).

Function
REQ-016 The FSM SHALL have exactly the states IDLE, LOAD, ROUND, FINAL and DONE.
REQ-017 IDLE with start=1 SHALL go to LOAD; otherwise it SHALL stay in IDLE.
REQ-018 LOAD SHALL last one cycle with ld_state=ld_key=1 and round=0, then go to ROUND with round=1.
REQ-019 ROUND SHALL assert state_en=key_en=1 and increment round each cycle; when round=NR-1 it SHALL go to FINAL.
REQ-020 FINAL SHALL assert state_en=key_en=last_round=1 with round=NR for one cycle, then go to DONE.
REQ-021 DONE SHALL hold done=1; ack=1 SHALL return the FSM to IDLE on the next cycle.
REQ-022 Latency: with start sampled at cycle 0, done SHALL first be high at cycle NR+2.
REQ-023 start outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-024 start and ack both high in DONE: ack wins, the FSM goes to IDLE, and start is not captured.
REQ-025 rcon SHALL be 0x01 in round 1 and the GF(2^8) doubling of the previous value in each later round: shift left, XOR 0x1b if bit 7 was set (round 9 = 0x1b, round 10 = 0x36).
REQ-026 rcon SHALL be 0x00 in IDLE, LOAD and DONE.
REQ-027 All outputs SHALL be decoded from registered state only; there SHALL be no combinational input-to-output path.
REQ-028 round SHALL never exceed NR and SHALL never wrap.

Reset
REQ-029 rst=0 at a clock edge SHALL force IDLE, round=0 and rcon register=0x01 internally, with all outputs 0, regardless of current state (including mid-operation).
REQ-030 The first cycle after rst rises SHALL accept start.

Configuration
REQ-031 Macro AES_ABORT_EN defined: the abort port exists; abort=1 in LOAD, ROUND or FINAL SHALL go to IDLE the next cycle with done never asserted; abort is ignored in IDLE and DONE.
REQ-032 AES_ABORT_EN undefined: the abort port and its logic are absent, and an operation always runs to DONE.

Structure
REQ-033 Package aes_ctrl_pkg SHALL hold the state enum typedef, the constants RCON_INIT=8'h01 and RCON_POLY=8'h1b, and the default NR.
REQ-034 Sub-module aes_rcon_gen SHALL implement the rcon register and xtime step, with enable and reload inputs.

Verification
REQ-035 Single op with NR=10: start pulse at cycle 0 -> LOAD at cycle 1, round 1..9 at cycles 2..10, FINAL at cycle 11, done at cycle 12.
REQ-036 rcon trace across rounds 1..10 -> 01,02,04,08,10,20,40,80,1b,36.
REQ-037 start held high for 20 cycles with ack=0 -> exactly one operation; done stays high; busy=0 in DONE.
REQ-038 ack delayed 5 cycles, then start and ack high together -> IDLE, no new LOAD; the next start pulse begins a new operation.
REQ-039 rst=0 at round 5 -> all outputs 0 on the next cycle; a new start completes normally.
REQ-040 With AES_ABORT_EN, abort=1 at round 3 -> IDLE next cycle, done never asserted, rcon=0x00.
